// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline boundary register.
// Control bundle bit positions and the default bubble kill mask.
package pipe_pkg;

  localparam int CTRL_W_DEF = 8;

  localparam int CTRL_REGDST   = 7;
  localparam int CTRL_ALUOP_HI = 6;
  localparam int CTRL_ALUOP_LO = 5;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_REGWRITE = 1;
  localparam int CTRL_MEMTOREG = 0;

  // MemRead, MemWrite, RegWrite must never fire on a bubble.
  localparam logic [CTRL_W_DEF-1:0] CTRL_KILL_DEF = 8'b0000_1110;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Stall/flush/valid bundle between two adjacent pipeline stages.
// master drives the upstream side, slave is the boundary register.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = 128
) ();

  logic              Stall_In;
  logic              Flush_In;
  logic              Valid_In;
  logic [CTRL_W-1:0] Ctrl_In;
  logic [DATA_W-1:0] Data_In;
  logic              Stall_Out;
  logic              Valid_Out;
  logic [CTRL_W-1:0] Ctrl_Out;
  logic [DATA_W-1:0] Data_Out;

  modport master (
    output Stall_In, Flush_In, Valid_In, Ctrl_In, Data_In,
    input  Stall_Out, Valid_Out, Ctrl_Out, Data_Out
  );

  modport slave (
    input  Stall_In, Flush_In, Valid_In, Ctrl_In, Data_In,
    output Stall_Out, Valid_Out, Ctrl_Out, Data_Out
  );

endinterface

// File: rtl/pipe_slot.sv
// One boundary slot: valid/ctrl/data register with load and kill.
// Bubbles always carry ctrl with the kill-mask bits cleared.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int                CTRL_W    = CTRL_W_DEF,
  parameter int                DATA_W    = 128,
  parameter logic [CTRL_W-1:0] KILL_MASK = {CTRL_W{1'b1}}
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              load,
  input  logic              flush,
  input  logic              src_valid,
  input  logic [CTRL_W-1:0] src_ctrl,
  input  logic [DATA_W-1:0] src_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // Reset beats flush, flush beats load; data is held on flush.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      ctrl  <= ctrl & ~KILL_MASK;
    end else if (load) begin
      valid <= src_valid;
      ctrl  <= src_valid ? src_ctrl
                         : (src_ctrl & ~KILL_MASK);
      data  <= src_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline boundary register: DEPTH slots, stall,
// flush and bubble collapse. Option: PIPE_STAGE_REG_PERF_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                CTRL_W         = CTRL_W_DEF,
  parameter int                DATA_W         = 128,
  parameter int                DEPTH          = 1,
  parameter logic [CTRL_W-1:0] CTRL_KILL_MASK = {CTRL_W{1'b1}}
) (
  input  logic             Clk,
  input  logic             Rst,
  pipe_stage_reg_if.slave  bus
`ifdef PIPE_STAGE_REG_PERF_EN
  ,
  output logic [31:0]      Stall_Cnt,
  output logic [31:0]      Bubble_Cnt
`endif
);

  logic [DEPTH:0]    en;
  logic [DEPTH:0]    sv;
  logic [CTRL_W-1:0] sc [DEPTH+1];
  logic [DATA_W-1:0] sd [DEPTH+1];
  logic              stall_o;

  assign sv[0] = bus.Valid_In;
  assign sc[0] = bus.Ctrl_In;
  assign sd[0] = bus.Data_In;

  // Load enables ripple from the output back; empty slots absorb.
  always_comb begin
    en        = '0;
    en[DEPTH] = !bus.Stall_In;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      en[k] = !sv[k+1] || en[k+1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    pipe_slot #(
      .CTRL_W    (CTRL_W),
      .DATA_W    (DATA_W),
      .KILL_MASK (CTRL_KILL_MASK)
    ) u_slot (
      .Clk       (Clk),
      .Rst       (Rst),
      .load      (en[k]),
      .flush     (bus.Flush_In),
      .src_valid (sv[k]),
      .src_ctrl  (sc[k]),
      .src_data  (sd[k]),
      .valid     (sv[k+1]),
      .ctrl      (sc[k+1]),
      .data      (sd[k+1])
    );
  end

  assign stall_o       = !en[0] && !Rst;
  assign bus.Stall_Out = stall_o;
  assign bus.Valid_Out = sv[DEPTH];
  assign bus.Ctrl_Out  = sc[DEPTH];
  assign bus.Data_Out  = sd[DEPTH];

`ifdef PIPE_STAGE_REG_PERF_EN
  // Saturating stall and output-bubble counters.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Stall_Cnt  <= '0;
      Bubble_Cnt <= '0;
    end else begin
      if (stall_o && Stall_Cnt != '1)
        Stall_Cnt <= Stall_Cnt + 32'd1;
      if (!sv[DEPTH] && !bus.Stall_In && Bubble_Cnt != '1)
        Bubble_Cnt <= Bubble_Cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (DEPTH=1 and DEPTH=3).
// Perf counter checks compile in with PIPE_STAGE_REG_PERF_EN.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst3;
  int   n_chk  = 0;
  int   n_fail = 0;

  pipe_stage_reg_if #(.CTRL_W(8), .DATA_W(128)) b1 ();
  pipe_stage_reg_if #(.CTRL_W(8), .DATA_W(128)) b3 ();

`ifdef PIPE_STAGE_REG_PERF_EN
  logic [31:0] sc1, bc1, sc3, bc3;
`endif

  pipe_stage_reg #(
    .CTRL_W(8), .DATA_W(128), .DEPTH(1),
    .CTRL_KILL_MASK(CTRL_KILL_DEF)
  ) u1 (
    .Clk(clk), .Rst(rst1), .bus(b1)
`ifdef PIPE_STAGE_REG_PERF_EN
    , .Stall_Cnt(sc1), .Bubble_Cnt(bc1)
`endif
  );

  pipe_stage_reg #(
    .CTRL_W(8), .DATA_W(128), .DEPTH(3),
    .CTRL_KILL_MASK(CTRL_KILL_DEF)
  ) u3 (
    .Clk(clk), .Rst(rst3), .bus(b3)
`ifdef PIPE_STAGE_REG_PERF_EN
    , .Stall_Cnt(sc3), .Bubble_Cnt(bc3)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv3(input logic v, input logic [7:0] c,
                      input logic [127:0] d);
    b3.Valid_In = v;
    b3.Ctrl_In  = c;
    b3.Data_In  = d;
  endtask

  task automatic reset3();
    rst3 = 1'b1;
    b3.Stall_In = 1'b0;
    b3.Flush_In = 1'b0;
    drv3(1'b0, 8'h00, '0);
    tick();
    rst3 = 1'b0;
  endtask

  task automatic test_reset();
    rst1 = 1'b1;
    b1.Stall_In = 1'b0;
    b1.Flush_In = 1'b0;
    b1.Valid_In = 1'b1;
    b1.Ctrl_In  = 8'hFF;
    b1.Data_In  = '1;
    tick();
    tick();
    n_chk++;
    if (b1.Valid_Out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid got %b want 0", b1.Valid_Out);
    end
    n_chk++;
    if (b1.Ctrl_Out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl got %h want 00", b1.Ctrl_Out);
    end
    n_chk++;
    if (b1.Data_Out !== 128'd0) begin
      n_fail++;
      $display("FAIL reset_data got %h want 0", b1.Data_Out);
    end
    n_chk++;
    if (b1.Stall_Out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stall got %b want 0", b1.Stall_Out);
    end
    rst1 = 1'b0;
  endtask

  task automatic test_streaming();
    logic [7:0] ec;
    reset3();
    for (int t = 0; t < 8; t++) begin
      if (t < 5) drv3(1'b1, 8'(2 + 4 * t), 128'(t + 1));
      else       drv3(1'b0, 8'h00, '0);
      tick();
      if (t >= 2) begin
        ec = 8'(2 + 4 * (t - 2));
        n_chk++;
        if (b3.Valid_Out !== (t - 2 < 5)) begin
          n_fail++;
          $display("FAIL stream_valid t=%0d got %b", t, b3.Valid_Out);
        end
        if (t - 2 < 5) begin
          n_chk++;
          if (b3.Ctrl_Out !== ec) begin
            n_fail++;
            $display("FAIL stream_ctrl t=%0d got %h want %h",
                     t, b3.Ctrl_Out, ec);
          end
          n_chk++;
          if (b3.Data_Out !== 128'(t - 1)) begin
            n_fail++;
            $display("FAIL stream_data t=%0d got %0d want %0d",
                     t, b3.Data_Out, t - 1);
          end
        end
      end else begin
        n_chk++;
        if (b3.Valid_Out !== 1'b0) begin
          n_fail++;
          $display("FAIL stream_early t=%0d got %b want 0",
                   t, b3.Valid_Out);
        end
      end
    end
  endtask

  task automatic test_bubble_mask();
    b1.Valid_In = 1'b0;
    b1.Ctrl_In  = 8'hFF;
    b1.Data_In  = 128'h1234;
    tick();
    n_chk++;
    if (b1.Valid_Out !== 1'b0) begin
      n_fail++;
      $display("FAIL bubble_valid got %b want 0", b1.Valid_Out);
    end
    n_chk++;
    if (b1.Ctrl_Out !== 8'hF1) begin
      n_fail++;
      $display("FAIL bubble_ctrl got %h want f1", b1.Ctrl_Out);
    end
  endtask

  task automatic test_capture();
    b1.Valid_In = 1'b1;
    b1.Ctrl_In  = 8'hA5;
    b1.Data_In  = 128'hBEEF;
    tick();
    n_chk++;
    if (b1.Valid_Out !== 1'b1 || b1.Ctrl_Out !== 8'hA5 ||
        b1.Data_Out !== 128'hBEEF) begin
      n_fail++;
      $display("FAIL capture got v=%b c=%h d=%h want 1 a5 beef",
               b1.Valid_Out, b1.Ctrl_Out, b1.Data_Out);
    end
  endtask

  task automatic test_stall_collapse();
    reset3();
    drv3(1'b1, 8'hFF, 128'hA);
    tick();
    drv3(1'b0, 8'h00, '0);
    tick();
    drv3(1'b1, 8'h12, 128'hB);
    tick();
    n_chk++;
    if (b3.Valid_Out !== 1'b1 || b3.Data_Out !== 128'hA) begin
      n_fail++;
      $display("FAIL collapse_setup got v=%b d=%h want 1 a",
               b3.Valid_Out, b3.Data_Out);
    end
    b3.Stall_In = 1'b1;
    drv3(1'b1, 8'h22, 128'hC);
    #1;
    n_chk++;
    if (b3.Stall_Out !== 1'b0) begin
      n_fail++;
      $display("FAIL collapse_accept got %b want 0", b3.Stall_Out);
    end
    tick();
    n_chk++;
    if (b3.Stall_Out !== 1'b1) begin
      n_fail++;
      $display("FAIL collapse_full got %b want 1", b3.Stall_Out);
    end
    n_chk++;
    if (b3.Data_Out !== 128'hA || b3.Valid_Out !== 1'b1) begin
      n_fail++;
      $display("FAIL collapse_hold got v=%b d=%h want 1 a",
               b3.Valid_Out, b3.Data_Out);
    end
    drv3(1'b1, 8'h32, 128'hD);
    tick();
    n_chk++;
    if (b3.Data_Out !== 128'hA || b3.Stall_Out !== 1'b1) begin
      n_fail++;
      $display("FAIL collapse_hold2 got d=%h s=%b want a 1",
               b3.Data_Out, b3.Stall_Out);
    end
  endtask

  task automatic test_flush_over_stall();
    b3.Stall_In = 1'b1;
    b3.Flush_In = 1'b1;
    drv3(1'b1, 8'h0E, 128'hE);
    tick();
    b3.Flush_In = 1'b0;
    #1;
    n_chk++;
    if (b3.Stall_Out !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_stall got %b want 0", b3.Stall_Out);
    end
    n_chk++;
    if (b3.Valid_Out !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_valid got %b want 0", b3.Valid_Out);
    end
    n_chk++;
    if (b3.Ctrl_Out !== 8'hF1) begin
      n_fail++;
      $display("FAIL flush_ctrl got %h want f1", b3.Ctrl_Out);
    end
    n_chk++;
    if (b3.Data_Out !== 128'hA) begin
      n_fail++;
      $display("FAIL flush_data got %h want a", b3.Data_Out);
    end
    b3.Stall_In = 1'b0;
    drv3(1'b0, 8'h00, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (b3.Valid_Out !== 1'b0 ||
          (b3.Ctrl_Out & CTRL_KILL_DEF) !== 8'h00) begin
        n_fail++;
        $display("FAIL flush_drain i=%0d got v=%b c=%h want 0 masked",
                 i, b3.Valid_Out, b3.Ctrl_Out);
      end
    end
  endtask

`ifdef PIPE_STAGE_REG_PERF_EN
  task automatic test_perf();
    rst3 = 1'b1;
    b3.Stall_In = 1'b1;
    b3.Flush_In = 1'b0;
    drv3(1'b0, 8'h00, '0);
    tick();
    rst3 = 1'b0;
    n_chk++;
    if (sc3 !== 32'd0 || bc3 !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_reset got s=%0d b=%0d want 0 0", sc3, bc3);
    end
    drv3(1'b1, 8'h02, 128'h5);
    for (int i = 0; i < 7; i++) tick();
    b3.Stall_In = 1'b0;
    drv3(1'b0, 8'h00, '0);
    for (int i = 0; i < 5; i++) tick();
    b3.Stall_In = 1'b1;
    n_chk++;
    if (sc3 !== 32'd4) begin
      n_fail++;
      $display("FAIL perf_stall got %0d want 4", sc3);
    end
    n_chk++;
    if (bc3 !== 32'd2) begin
      n_fail++;
      $display("FAIL perf_bubble got %0d want 2", bc3);
    end
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    n_chk++;
    if (sc3 !== 32'd0 || bc3 !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_clear got s=%0d b=%0d want 0 0", sc3, bc3);
    end
  endtask
`endif

  initial begin
    rst3 = 1'b1;
    b3.Stall_In = 1'b0;
    b3.Flush_In = 1'b0;
    drv3(1'b0, 8'h00, '0);
    test_reset();
    test_streaming();
    test_bubble_mask();
    test_capture();
    test_stall_collapse();
    test_flush_over_stall();
`ifdef PIPE_STAGE_REG_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
